// File: rtl/sha_mem_pkg.sv
// Shared types for the SHA memory arbiter: FSM states and the registered memory request.
package sha_mem_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 32;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Widths follow the package defaults; resize here together with the arbiter parameters.
  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    // NOTE: every variable gets a default before the search so no latch is inferred.
    gnt_o    = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_idx = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o         = 1'b1;
        idx_o           = cand_idx;
        gnt_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sha_mem_arbiter.sv
// Round-robin arbiter with locked bursts sharing one single-port SRAM among NUM_REQ hash cores.
module sha_mem_arbiter
  import sha_mem_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_clk,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_write_data,
  input  logic [DATA_W-1:0]         mem_read_data
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic [NUM_REQ-1:0] arb_req, arb_gnt, owner_mask;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;

  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];
  mem_req_t          sel_req, mem_q, mem_d;

  logic             rd_pend_q, rd_pend_d;
  logic [IDX_W-1:0] rd_pend_idx_q, rd_pend_idx_d;
  logic             rtag_valid_q;
  logic [IDX_W-1:0] rtag_idx_q;

  // During a burst only the owner is visible to the picker.
  assign owner_mask = NUM_REQ'(1) << owner_q;
  assign arb_req    = (state_q == BURST) ? (req & owner_mask) : req;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req_i   (arb_req),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    sel_req.we    = req_we[arb_idx];
    sel_req.addr  = addr_arr[arb_idx];
    sel_req.wdata = wdata_arr[arb_idx];
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (arb_valid) begin
      rr_ptr_d = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
      owner_d  = arb_idx;
      if (req_lock[arb_idx]) begin
        burst_cnt_d = (state_q == ARB) ? CNT_W'(1) : burst_cnt_q + 1'b1;
        state_d     = (burst_cnt_d == CNT_W'(MAX_BURST)) ? ARB : BURST;
      end else begin
        burst_cnt_d = '0;
        state_d     = ARB;
      end
    end else if (state_q == BURST) begin
      // Owner stopped requesting: the lock is released without a grant.
      burst_cnt_d = '0;
      state_d     = ARB;
    end
  end

  always_comb begin
    mem_d         = mem_q;
    mem_d.we      = 1'b0;
    rd_pend_d     = 1'b0;
    rd_pend_idx_d = rd_pend_idx_q;
    if (arb_valid) begin
      mem_d         = sel_req;
      rd_pend_d     = !sel_req.we;
      rd_pend_idx_d = arb_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: registers use non-blocking assignments only so every flop sees pre-edge values.
      state_q       <= ARB;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      burst_cnt_q   <= '0;
      mem_q         <= '0;
      rd_pend_q     <= 1'b0;
      rd_pend_idx_q <= '0;
      rtag_valid_q  <= 1'b0;
      rtag_idx_q    <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      burst_cnt_q   <= burst_cnt_d;
      mem_q         <= mem_d;
      rd_pend_q     <= rd_pend_d;
      rd_pend_idx_q <= rd_pend_idx_d;
      rtag_valid_q  <= rd_pend_q;
      rtag_idx_q    <= rd_pend_idx_q;
    end
  end

  assign gnt            = reset ? '0 : arb_gnt;
  assign rvalid         = rtag_valid_q ? (NUM_REQ'(1) << rtag_idx_q) : '0;
  assign rdata          = mem_read_data;
  assign mem_clk        = clk;
  assign mem_we         = mem_q.we;
  assign mem_addr       = mem_q.addr;
  assign mem_write_data = mem_q.wdata;

endmodule

// File: tb/tb_sha_mem_arbiter.sv
// Self-checking bench: SRAM model, transaction-level reference model, directed and random traffic.
module tb_sha_mem_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 16;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_REQ-1:0]        req = '0, req_we = '0, req_lock = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ*DATA_W-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]        gnt, rvalid;
  logic [DATA_W-1:0]         rdata, mem_write_data, mem_read_data;
  logic                      mem_clk, mem_we;
  logic [ADDR_W-1:0]         mem_addr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sha_mem_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // SRAM: read data valid the cycle after the address is presented.
  logic [DATA_W-1:0] sram      [0:65535];
  logic [DATA_W-1:0] model_mem [0:65535];

  function automatic logic [31:0] init_word(input int a);
    return (a == 5) ? 32'hA5A5_0001 : (32'h1234_0000 + 32'(a));
  endfunction

  initial begin
    for (int a = 0; a < 65536; a++) begin
      sram[a]      = init_word(a);
      model_mem[a] = init_word(a);
    end
  end

  always @(posedge mem_clk) begin
    if (mem_we) sram[mem_addr] <= mem_write_data;
    mem_read_data <= sram[mem_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: arbitration state plus expected registered outputs.
  int          m_rr = 0, m_owner = -1, m_cnt = 0, m_last_gnt = -1, g_pick;
  logic        exp_we = 1'b0;
  logic [15:0] exp_addr = '0;
  logic [31:0] exp_wdata = '0;
  logic        rd1_v = 1'b0, rd2_v = 1'b0;
  int          rd1_idx = 0, rd2_idx = 0;
  logic [31:0] rd1_data = '0, rd2_data = '0;
  logic [NUM_REQ-1:0] exp_gnt, exp_rv;

  function automatic int model_pick();
    if (m_owner >= 0) return req[m_owner] ? m_owner : -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req[(m_rr + k) % NUM_REQ]) return (m_rr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_rr = 0; m_owner = -1; m_cnt = 0;
    exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
    rd1_v = 1'b0; rd2_v = 1'b0;
  endtask

  task automatic model_step(input int g);
    logic [15:0] a;
    logic [31:0] d;
    rd2_v = rd1_v; rd2_idx = rd1_idx; rd2_data = rd1_data;
    rd1_v = 1'b0;
    if (g < 0) begin
      exp_we  = 1'b0;
      m_owner = -1;
    end else begin
      a = req_addr[g*ADDR_W +: ADDR_W];
      d = req_wdata[g*DATA_W +: DATA_W];
      exp_we = req_we[g]; exp_addr = a; exp_wdata = d;
      if (req_we[g]) model_mem[a] = d;
      else begin rd1_v = 1'b1; rd1_idx = g; rd1_data = model_mem[a]; end
      m_rr = (g + 1) % NUM_REQ;
      if (req_lock[g]) begin
        m_cnt   = (m_owner >= 0) ? m_cnt + 1 : 1;
        m_owner = (m_cnt < MAX_BURST) ? g : -1;
      end else begin
        m_owner = -1;
      end
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    check("mem_we", mem_we, exp_we);
    check("mem_addr", mem_addr, exp_addr);
    check("mem_write_data", mem_write_data, exp_wdata);
    exp_rv = rd2_v ? (NUM_REQ'(1) << rd2_idx) : '0;
    check("rvalid", rvalid, exp_rv);
    if (rd2_v) check("rdata", rdata, rd2_data);
    g_pick  = reset ? -1 : model_pick();
    exp_gnt = (g_pick >= 0) ? (NUM_REQ'(1) << g_pick) : '0;
    check("gnt", gnt, exp_gnt);
    m_last_gnt = g_pick;
    if (reset) model_reset();
    else model_step(g_pick);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic at_mid();
    @(negedge clk); #2;
  endtask

  task automatic set_req(input int i, input logic we, input logic [15:0] a,
                         input logic [31:0] d, input logic lk);
    req[i] = 1'b1; req_we[i] = we; req_lock[i] = lk;
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic clr_req(input int i);
    req[i] = 1'b0; req_lock[i] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; req_lock = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    tick();

    // 1: single read of addr 5
    do_reset();
    set_req(0, 1'b0, 16'd5, 32'h0, 1'b0);
    at_mid(); check("t1_gnt", gnt, 4'b0001);
    tick(); clr_req(0);
    at_mid(); check("t1_mem_addr", mem_addr, 16'd5); check("t1_mem_we", mem_we, 1'b0);
    tick();
    at_mid(); check("t1_rvalid", rvalid, 4'b0001); check("t1_rdata", rdata, 32'hA5A5_0001);
    tick();

    // 2: four continuous readers rotate one grant per cycle
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 16'(100 + i), 32'h0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      at_mid();
      check("t2_gnt", gnt, 4'b0001 << (k % 4));
      if (k >= 2) check("t2_rvalid", rvalid, 4'b0001 << ((k - 2) % 4));
      tick();
    end
    req = '0;

    // 3: locked burst capped at MAX_BURST, then waiting req2
    do_reset();
    set_req(1, 1'b0, 16'd0, 32'h0, 1'b1);
    set_req(2, 1'b0, 16'd200, 32'h0, 1'b0);
    for (int k = 0; k < 18; k++) begin
      at_mid();
      check("t3_gnt", gnt, (k < 16 || k == 17) ? 4'b0010 : 4'b0100);
      tick();
      if (k < 15) set_req(1, 1'b0, 16'(k + 1), 32'h0, 1'b1);
      if (k == 16) clr_req(2);
    end
    req = '0; req_lock = '0;

    // 4: write then read back
    do_reset();
    set_req(3, 1'b1, 16'd1000, 32'hDEAD_BEEF, 1'b0);
    at_mid(); check("t4_gnt_w", gnt, 4'b1000);
    tick(); set_req(3, 1'b0, 16'd1000, 32'h0, 1'b0);
    at_mid();
    check("t4_we", mem_we, 1'b1); check("t4_addr", mem_addr, 16'd1000);
    check("t4_wdata", mem_write_data, 32'hDEAD_BEEF); check("t4_gnt_r", gnt, 4'b1000);
    tick(); clr_req(3);
    at_mid(); check("t4_we_once", mem_we, 1'b0); check("t4_no_rvalid_w", rvalid, 4'b0000);
    tick();
    at_mid(); check("t4_rvalid", rvalid, 4'b1000); check("t4_rdata", rdata, 32'hDEAD_BEEF);
    tick();

    // 5: owner drops req mid-burst while req0 waits
    do_reset();
    set_req(2, 1'b0, 16'd300, 32'h0, 1'b1);
    at_mid(); check("t5_gnt0", gnt, 4'b0100); tick();
    set_req(0, 1'b0, 16'd400, 32'h0, 1'b0); set_req(2, 1'b0, 16'd301, 32'h0, 1'b1);
    at_mid(); check("t5_gnt1", gnt, 4'b0100); tick();
    set_req(2, 1'b0, 16'd302, 32'h0, 1'b1);
    at_mid(); check("t5_gnt2", gnt, 4'b0100); tick();
    clr_req(2);
    at_mid(); check("t5_gap", gnt, 4'b0000); tick();
    at_mid(); check("t5_req0", gnt, 4'b0001); tick();
    clr_req(0);

    // 6: reset right after a read grant
    do_reset();
    set_req(1, 1'b0, 16'd7, 32'h0, 1'b0);
    at_mid(); check("t6_gnt", gnt, 4'b0010); tick();
    clr_req(1); reset = 1'b1;
    set_req(3, 1'b0, 16'd9, 32'h0, 1'b0);
    at_mid(); check("t6_gnt_in_reset", gnt, 4'b0000); check("t6_addr_pre", mem_addr, 16'd7);
    tick(); reset = 1'b0;
    set_req(0, 1'b0, 16'd11, 32'h0, 1'b0);
    at_mid();
    check("t6_rvalid", rvalid, 4'b0000); check("t6_we", mem_we, 1'b0);
    check("t6_addr", mem_addr, 16'd0); check("t6_first", gnt, 4'b0001);
    tick(); clr_req(0);
    at_mid(); check("t6_rvalid_late", rvalid, 4'b0000);
    tick(); clr_req(3);

    // Random traffic with occasional resets
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req[i] || m_last_gnt == i) begin
          if ($urandom_range(0, 3) != 0) begin
            set_req(i, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), $urandom,
                    (req[i] && req_lock[i]) ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 4) == 0));
          end else begin
            clr_req(i);
          end
        end
      end
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 1'b0; req = '0; req_lock = '0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
